minicpu_sram_arbiter: RTL and testbench
=======================================

// Module: minicpu_sram_arbiter
// PURPOSE
// - Shares one single-port synchronous SRAM between the miniCPU instruction-fetch and data (ld.w/st.w) requesters.
// - Sits between the CPU core and the unified memory; replaces separate inst/data SRAMs.
// - Issues at most one SRAM access per cycle and returns responses in order.
// - Supplies per-requester addr_ok/data_ok handshakes; the core stalls on them.
// PARAMETERS
// - ADDR_W        32  address width, byte address
// - DATA_W        32  data width
// - MAX_DATA_RUN  4   consecutive data grants allowed while inst_req is pending before inst is forced a grant (1..15)
// PORTS
// - clk            in   1       clock
// - reset          in   1       synchronous, active-high
// - inst_req       in   1       fetch request, held until inst_addr_ok
// - inst_addr      in   ADDR_W  fetch address
// - inst_addr_ok   out  1       fetch request accepted this cycle
// - inst_data_ok   out  1       fetch data valid this cycle
// - inst_rdata     out  DATA_W  fetch data
// - data_req       in   1       load/store request, held until data_addr_ok
// - data_we        in   1       1=store, 0=load
// - data_addr      in   ADDR_W  load/store address
// - data_wdata     in   DATA_W  store data
// - data_addr_ok   out  1       load/store accepted this cycle
// - data_data_ok   out  1       load data valid / store complete this cycle
// - data_rdata     out  DATA_W  load data
// - sram_en        out  1       SRAM access enable
// - sram_we        out  1       SRAM write enable
// - sram_addr      out  ADDR_W  SRAM address
// - sram_wdata     out  DATA_W  SRAM write data
// - sram_rdata     in   DATA_W  SRAM read data, valid 1 cycle after sram_en
// BEHAVIOUR
// - Reset: state IDLE, run counter 0, all outputs 0; in-flight access discarded, no data_ok follows reset.
// - States: IDLE (nothing outstanding), INST_WAIT, DATA_WAIT (one access issued the previous cycle).
// - Grant each cycle, combinational from requests and state; valid in every state (back-to-back, 1 access/cycle):
//   - data_req only -> data; inst_req only -> inst.
//   - both -> data, unless run_cnt == MAX_DATA_RUN, then inst.
// - Granted cycle:
//   - sram_en=1; sram_we=data_we for data, else 0; addr/wdata driven from the winner.
//   - Winner's addr_ok=1; loser's addr_ok=0.
//   - Next state = winner's WAIT state.
// - No grant: sram_en=0, sram_we=0; next state IDLE.
// - INST_WAIT: inst_data_ok=1, inst_rdata=sram_rdata. DATA_WAIT: data_data_ok=1, data_rdata=sram_rdata.
//   - Stores also give data_data_ok; data_rdata is don't-care for stores.
// - Latency: request accepted in cycle N -> data_ok in cycle N+1; fixed, no bubbles.
// - run_cnt (4 bit):
//   - +1 on a data grant while inst_req=1, saturating at MAX_DATA_RUN.
//   - Cleared on an inst grant, and whenever inst_req=0.
// - sram_we is never asserted without sram_en. Addresses pass through unchanged; alignment is the core's job.
// - rdata outputs are 0 when the matching data_ok is 0.
// STRUCTURE
// - Shared package minicpu_pkg: state encoding (IDLE/INST_WAIT/DATA_WAIT, 2 bit), default ADDR_W/DATA_W.
// - Sub-module minicpu_prio_sel: 2-way priority select with starvation counter (grant_inst, grant_data, run_cnt).
// - Top level holds the FSM register and the SRAM/response muxing.
// TESTING
// - Reset, then inst_req only at 0x1c000000 for 3 cycles -> inst_addr_ok each cycle; inst_data_ok cycles 2..4; rdata = mem[0x1c000000..08].
// - inst_req and data_req (load 0x100) together -> data granted first; inst_addr_ok next cycle; data_data_ok then inst_data_ok on consecutive cycles.
// - Store 0xdeadbeef to 0x200, then load 0x200 on the next cycle -> sram_we=1 once; data_data_ok twice; load returns 0xdeadbeef.
// - inst_req and data_req both held high for 10 cycles (MAX_DATA_RUN=4) -> grants DDDDIDDDDI.
// - Reset asserted in the cycle after a load is accepted -> no data_data_ok; all outputs 0 the cycle after reset.
// - No requests for 5 cycles -> sram_en=0, state IDLE, no addr_ok or data_ok.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared definitions for the miniCPU memory path: FSM state encoding and
// default bus widths.
package minicpu_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // IDLE: nothing outstanding; *_WAIT: one access issued last cycle,
    // its response (read data or store completion) is returned this cycle.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INST_WAIT = 2'd1,
        ST_DATA_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/minicpu_prio_sel.sv
// Two-way priority select between fetch and load/store: data wins ties
// until it has won MAX_DATA_RUN times in a row over a waiting fetch.
module minicpu_prio_sel #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inst_req,
    input  logic       data_req,
    output logic       grant_inst,
    output logic       grant_data,
    output logic [3:0] run_cnt
);
    localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);

    logic [3:0] run_cnt_q, run_cnt_d;

    // No grant while reset is high, so nothing is issued into a dying cycle.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!reset) begin
            if (data_req && !(inst_req && run_cnt_q == MAX_RUN)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    // The run only counts data wins that actually made a fetch wait.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!inst_req || grant_inst) begin
            run_cnt_d = 4'd0;
        end else if (grant_data && run_cnt_q != MAX_RUN) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= 4'd0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign run_cnt = run_cnt_q;

endmodule

// File: rtl/minicpu_sram_arbiter.sv
// Shares one single-port synchronous SRAM between miniCPU fetch and
// load/store; one access per cycle, responses exactly one cycle later.
module minicpu_sram_arbiter
    import minicpu_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [1:0]        dbg_state,
    output logic [3:0]        dbg_run_cnt
);
    // Handshake: a requester holds *_req (with its address/data) until it
    // sees *_addr_ok in the same cycle; *_data_ok follows exactly one cycle
    // after that acceptance and is a single-cycle pulse with no back-pressure.

    state_e state_q, state_d;
    logic   grant_inst, grant_data;

    minicpu_prio_sel #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_prio_sel (
        .clk       (clk),
        .reset     (reset),
        .inst_req  (inst_req),
        .data_req  (data_req),
        .grant_inst(grant_inst),
        .grant_data(grant_data),
        .run_cnt   (dbg_run_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = ST_IDLE;
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        if (grant_data) begin
            state_d      = ST_DATA_WAIT;
            sram_en      = 1'b1;
            sram_we      = data_we;
            sram_addr    = data_addr;
            sram_wdata   = data_wdata;
            data_addr_ok = 1'b1;
        end else if (grant_inst) begin
            state_d      = ST_INST_WAIT;
            sram_en      = 1'b1;
            sram_addr    = inst_addr;
            inst_addr_ok = 1'b1;
        end
    end

    // Responses are masked during reset so an access in flight is dropped.
    always_comb begin
        inst_data_ok = !reset && (state_q == ST_INST_WAIT);
        data_data_ok = !reset && (state_q == ST_DATA_WAIT);
        inst_rdata   = inst_data_ok ? sram_rdata : '0;
        data_rdata   = data_data_ok ? sram_rdata : '0;
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_minicpu_sram_arbiter.sv
// Directed bench for minicpu_sram_arbiter with a behavioural single-port
// synchronous SRAM attached.
module tb_minicpu_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_en, sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_run_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    minicpu_sram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_RUN(4)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .dbg_state(dbg_state), .dbg_run_cnt(dbg_run_cnt)
    );

    // Preloaded SRAM contents; written words override these.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h1c00_0000: init_val = 32'h1c00_aaa0;
            32'h1c00_0004: init_val = 32'h1c00_aaa4;
            32'h1c00_0008: init_val = 32'h1c00_aaa8;
            32'h0000_0100: init_val = 32'h0000_5100;
            default:       init_val = a ^ 32'ha5a5_a5a5;
        endcase
    endfunction

    logic [31:0]  wmem [0:255];
    logic [255:0] written;
    wire  [7:0]   midx = sram_addr[9:2];

    always @(posedge clk) begin
        if (reset) begin
            written <= '0;
        end else if (sram_en && sram_we) begin
            wmem[midx]    <= sram_wdata;
            written[midx] <= 1'b1;
        end
        if (sram_en && !sram_we) begin
            sram_rdata <= written[midx] ? wmem[midx] : init_val(sram_addr);
        end
    end

    wire [5:0]   flags    = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en, sram_we};
    wire [133:0] all_outs = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                             data_rdata, sram_en, sram_we, sram_addr, sram_wdata};

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        inst_addr  = 32'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h200; data_wdata = 32'h1234;
        for (int c = 0; c < 2; c++) begin
            #4;
            total++;
            if (all_outs !== '0) begin
                bad++;
                $display("FAIL reset_outs cycle=%0d got=%h want=0", c, all_outs);
            end
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
        #4;
        total++;
        if (all_outs !== '0 || dbg_state !== 2'd0 || dbg_run_cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_release got=%h state=%0d cnt=%0d want=0", all_outs, dbg_state, dbg_run_cnt);
        end
        next_cycle();
    endtask

    task automatic test_inst_stream;
        logic [31:0] exp_rd [3];
        exp_rd = '{32'h1c00_aaa0, 32'h1c00_aaa4, 32'h1c00_aaa8};
        for (int c = 0; c < 4; c++) begin
            inst_req  = (c < 3);
            inst_addr = 32'h1c00_0000 + 32'(4 * c);
            #4;
            total++;
            if (flags !== {(c < 3), (c > 0), 1'b0, 1'b0, (c < 3), 1'b0}) begin
                bad++;
                $display("FAIL inst_flags cycle=%0d got=%b", c, flags);
            end
            if (c < 3) begin
                total++;
                if (sram_addr !== 32'h1c00_0000 + 32'(4 * c)) begin
                    bad++;
                    $display("FAIL inst_sram_addr cycle=%0d got=%h", c, sram_addr);
                end
            end
            if (c > 0) begin
                total++;
                if (inst_rdata !== exp_rd[c-1]) begin
                    bad++;
                    $display("FAIL inst_rdata cycle=%0d got=%h want=%h", c, inst_rdata, exp_rd[c-1]);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_both;
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        #4;
        total++;
        if (flags !== 6'b001010 || sram_addr !== 32'h100) begin
            bad++;
            $display("FAIL both_c0 flags=%b addr=%h want 001010/100", flags, sram_addr);
        end
        next_cycle();
        data_req = 1'b0;
        #4;
        total++;
        if (flags !== 6'b100110 || sram_addr !== 32'h1c00_0000 || dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL both_c1 flags=%b addr=%h state=%0d", flags, sram_addr, dbg_state);
        end
        total++;
        if (data_rdata !== 32'h0000_5100) begin
            bad++;
            $display("FAIL both_load_rdata got=%h want=00005100", data_rdata);
        end
        next_cycle();
        inst_req = 1'b0;
        #4;
        total++;
        if (flags !== 6'b010000 || inst_rdata !== 32'h1c00_aaa0) begin
            bad++;
            $display("FAIL both_c2 flags=%b rdata=%h want 010000/1c00aaa0", flags, inst_rdata);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_store_load;
        int we_cnt = 0;
        int ok_cnt = 0;
        logic [5:0] exp_f [3];
        exp_f = '{6'b001011, 6'b001110, 6'b000100};
        for (int c = 0; c < 3; c++) begin
            data_req   = (c < 2);
            data_we    = (c == 0);
            data_addr  = 32'h200;
            data_wdata = (c == 0) ? 32'hdead_beef : 32'h0;
            #4;
            we_cnt += int'(sram_we);
            ok_cnt += int'(data_data_ok);
            total++;
            if (flags !== exp_f[c]) begin
                bad++;
                $display("FAIL st_ld_flags cycle=%0d got=%b want=%b", c, flags, exp_f[c]);
            end
            if (c == 0) begin
                total++;
                if (sram_wdata !== 32'hdead_beef || sram_addr !== 32'h200) begin
                    bad++;
                    $display("FAIL store_bus wdata=%h addr=%h", sram_wdata, sram_addr);
                end
            end
            if (c == 2) begin
                total++;
                if (data_rdata !== 32'hdead_beef) begin
                    bad++;
                    $display("FAIL load_after_store got=%h want=deadbeef", data_rdata);
                end
            end
            next_cycle();
        end
        total++;
        if (we_cnt !== 1 || ok_cnt !== 2) begin
            bad++;
            $display("FAIL st_ld_counts we=%0d ok=%0d want 1/2", we_cnt, ok_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_starvation;
        string exp_g = "DDDDIDDDDI";
        byte   g;
        for (int i = 0; i < 10; i++) begin
            inst_req = 1'b1; inst_addr = 32'h1c00_0004;
            data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
            #4;
            if (inst_addr_ok && !data_addr_ok)      g = "I";
            else if (data_addr_ok && !inst_addr_ok) g = "D";
            else                                    g = "?";
            total++;
            if (g !== exp_g[i]) begin
                bad++;
                $display("FAIL starve_grant cycle=%0d got=%s want=%s", i, g, exp_g[i]);
            end
            total++;
            if (dbg_run_cnt !== 4'(i % 5)) begin
                bad++;
                $display("FAIL starve_run_cnt cycle=%0d got=%0d want=%0d", i, dbg_run_cnt, i % 5);
            end
            next_cycle();
        end
        idle_inputs();
        #4;
        total++;
        if (flags !== 6'b010000 || inst_rdata !== 32'h1c00_aaa4 || dbg_run_cnt !== 4'd0) begin
            bad++;
            $display("FAIL starve_tail flags=%b rdata=%h cnt=%0d", flags, inst_rdata, dbg_run_cnt);
        end
        next_cycle();
    endtask

    task automatic test_reset_midflight;
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h100;
        #4;
        total++;
        if (flags !== 6'b001010) begin
            bad++;
            $display("FAIL mid_accept flags=%b want=001010", flags);
        end
        next_cycle();
        reset = 1'b1;
        data_req = 1'b0;
        #4;
        total++;
        if (data_data_ok !== 1'b0 || all_outs !== '0) begin
            bad++;
            $display("FAIL mid_reset_cycle data_ok=%b outs=%h want 0", data_data_ok, all_outs);
        end
        next_cycle();
        reset = 1'b0;
        #4;
        total++;
        if (all_outs !== '0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL mid_after_reset outs=%h state=%0d want 0", all_outs, dbg_state);
        end
        next_cycle();
    endtask

    task automatic test_idle;
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            #4;
            total++;
            if (flags !== 6'b000000 || dbg_state !== 2'd0) begin
                bad++;
                $display("FAIL idle cycle=%0d flags=%b state=%0d", c, flags, dbg_state);
            end
            next_cycle();
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_inst_stream();
        test_both();
        test_store_load();
        test_starvation();
        test_reset_midflight();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
